wr_req_arbiter: RTL and testbench

- Two-requester write scheduler in front of the CCI write-request channel (wr_req_*), typically fed by the cache-line write buffer (port 0) and a direct/flush writer (port 1).
- Grants one cache-line write per cycle, tags it with mdata, and caps outstanding writes.
- Routes write responses back to the originating requester using the tag.
- Provides a drain/flush handshake so software can wait for all writes to land.

---
 rtl/wr_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_wr_req_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_req_arbiter.sv
`timescale 1ns/1ps
// Two-requester CCI write scheduler: arbitrates cache-line writes, tags them with mdata,
// caps outstanding writes, routes responses back by tag. WR_ARB_PRIO_EN selects fixed priority (port 1).
module wr_req_arbiter #(
    parameter int ADDR_LMT        = 20,
    parameter int MDATA           = 14,
    parameter int CACHE_WIDTH     = 512,
    parameter int MAX_OUTSTANDING = 32,
    parameter int CNT_W           = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   req0_valid,
    input  logic [ADDR_LMT-1:0]    req0_addr,
    input  logic [CACHE_WIDTH-1:0] req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [ADDR_LMT-1:0]    req1_addr,
    input  logic [CACHE_WIDTH-1:0] req1_data,
    output logic                   req1_ready,
    output logic [ADDR_LMT-1:0]    wr_req_addr,
    output logic [MDATA-1:0]       wr_req_mdata,
    output logic [CACHE_WIDTH-1:0] wr_req_data,
    output logic                   wr_req_en,
    input  logic                   wr_req_almostfull,
    input  logic                   wr_rsp0_valid,
    input  logic [MDATA-1:0]       wr_rsp0_mdata,
    input  logic                   wr_rsp1_valid,
    input  logic [MDATA-1:0]       wr_rsp1_mdata,
    output logic [1:0]             req0_done,
    output logic [1:0]             req1_done,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [CNT_W-1:0]       outstanding,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t             state_reg;
    logic [MDATA-2:0]   seq_reg;
    logic [CNT_W-1:0]   out_reg;
    logic [CNT_W-1:0]   out_next;
    logic               can_issue;
    logic               grant;
    logic               accept;
    logic               rsp0_ok;
    logic               rsp1_ok;
    logic [1:0]         rsp_cnt;
    logic [1:0]         done0_next;
    logic [1:0]         done1_next;
    logic               unused_rsp_seq;

`ifndef WR_ARB_PRIO_EN
    logic               rr_ptr_reg;
`endif

    assign unused_rsp_seq = ^{wr_rsp0_mdata[MDATA-2:0], wr_rsp1_mdata[MDATA-2:0]};

    assign can_issue = !rst && (state_reg == RUN) && start && !wr_req_almostfull
                       && (out_reg < MAX_CNT);

    always_comb begin
        grant = 1'b0;
`ifdef WR_ARB_PRIO_EN
        grant = req1_valid;
`else
        if (req0_valid && req1_valid)
            grant = rr_ptr_reg;
        else
            grant = req1_valid;
`endif
    end

    assign req0_ready = can_issue && req0_valid && !grant;
    assign req1_ready = can_issue && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    // Responses beyond the current count are stale (e.g. issued before a reset) and dropped.
    assign rsp0_ok = wr_rsp0_valid && (out_reg != '0);
    assign rsp1_ok = wr_rsp1_valid && (out_reg > CNT_W'(rsp0_ok));
    assign rsp_cnt = {1'b0, rsp0_ok} + {1'b0, rsp1_ok};

    assign done0_next = {1'b0, rsp0_ok && !wr_rsp0_mdata[MDATA-1]}
                      + {1'b0, rsp1_ok && !wr_rsp1_mdata[MDATA-1]};
    assign done1_next = {1'b0, rsp0_ok &&  wr_rsp0_mdata[MDATA-1]}
                      + {1'b0, rsp1_ok &&  wr_rsp1_mdata[MDATA-1]};

    assign out_next = out_reg + CNT_W'(accept) - CNT_W'(rsp_cnt);

    assign outstanding = out_reg;
    assign busy        = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            seq_reg      <= '0;
            out_reg      <= '0;
            wr_req_addr  <= '0;
            wr_req_mdata <= '0;
            wr_req_data  <= '0;
            wr_req_en    <= 1'b0;
            req0_done    <= '0;
            req1_done    <= '0;
            flush_done   <= 1'b0;
`ifndef WR_ARB_PRIO_EN
            rr_ptr_reg   <= 1'b0;
`endif
        end else begin
            wr_req_en  <= accept;
            out_reg    <= out_next;
            req0_done  <= done0_next;
            req1_done  <= done1_next;
            flush_done <= 1'b0;

            if (accept) begin
                wr_req_addr  <= grant ? req1_addr : req0_addr;
                wr_req_data  <= grant ? req1_data : req0_data;
                wr_req_mdata <= {grant, seq_reg};
                seq_reg      <= seq_reg + 1'b1;
`ifndef WR_ARB_PRIO_EN
                rr_ptr_reg   <= !grant;
`endif
            end

            case (state_reg)
                IDLE: begin
                    if (start)
                        state_reg <= RUN;
                end
                RUN: begin
                    if (flush)
                        state_reg <= DRAIN;
                    else if (!start && out_reg == '0)
                        state_reg <= IDLE;
                end
                DRAIN: begin
                    // Leave on the edge that retires the last write so flush_done aligns with outstanding==0.
                    if (out_next == '0) begin
                        state_reg  <= RUN;
                        flush_done <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_req_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for wr_req_arbiter: stimulus pushes expected writes, a negedge monitor
// pops and compares them; handshake, done, outstanding and flush values are checked inline.
module tb_wr_req_arbiter;

    localparam int AW = 20;
    localparam int MW = 14;
    localparam int DW = 512;
    localparam int CW = 6;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [MW-1:0] mdata;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] wr_req_addr;
    logic [MW-1:0] wr_req_mdata;
    logic [DW-1:0] wr_req_data;
    logic          wr_req_en;
    logic          wr_req_almostfull;
    logic          wr_rsp0_valid, wr_rsp1_valid;
    logic [MW-1:0] wr_rsp0_mdata, wr_rsp1_mdata;
    logic [1:0]    req0_done, req1_done;
    logic          flush;
    logic          flush_done;
    logic [CW-1:0] outstanding;
    logic          busy;

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    wr_t exp_q[$];
    wr_t mon_exp;
    int  seq;
    logic [AW-1:0] p0_addr, p1_addr;
    int          bv_port [4];
    logic [MW-1:0] bv_md [4];

    wr_req_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .req0_valid        (req0_valid),
        .req0_addr         (req0_addr),
        .req0_data         (req0_data),
        .req0_ready        (req0_ready),
        .req1_valid        (req1_valid),
        .req1_addr         (req1_addr),
        .req1_data         (req1_data),
        .req1_ready        (req1_ready),
        .wr_req_addr       (wr_req_addr),
        .wr_req_mdata      (wr_req_mdata),
        .wr_req_data       (wr_req_data),
        .wr_req_en         (wr_req_en),
        .wr_req_almostfull (wr_req_almostfull),
        .wr_rsp0_valid     (wr_rsp0_valid),
        .wr_rsp0_mdata     (wr_rsp0_mdata),
        .wr_rsp1_valid     (wr_rsp1_valid),
        .wr_rsp1_mdata     (wr_rsp1_mdata),
        .req0_done         (req0_done),
        .req1_done         (req1_done),
        .flush             (flush),
        .flush_done        (flush_done),
        .outstanding       (outstanding),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
        return {16{a[11:0], 20'hC3A5E}};
    endfunction

    function automatic wr_t mk_wr(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
        wr_t w;
        w.addr  = a;
        w.mdata = m;
        w.data  = d;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one line on port 0 and wait (bounded) for its handshake.
    task automatic accept_port0(input logic [AW-1:0] a);
        bit done_flag = 0;
        req0_valid = 1'b1;
        req0_addr  = a;
        req0_data  = mkdata(a);
        for (int i = 0; i < 40 && !done_flag; i++) begin
            @(negedge clk);
            if (req0_ready) begin
                exp_q.push_back(mk_wr(a, {1'b0, 13'(seq)}, mkdata(a)));
                seq++;
                done_flag = 1;
            end
            step();
        end
        req0_valid = 1'b0;
        if (!done_flag) begin
            total_cnt++;
            $display("FAIL accept_port0_timeout: got no ready, expected ready within 40 cycles");
        end
    endtask

    // Scoreboard monitor: every issued write must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && wr_req_en) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr 0x%0h mdata 0x%0h, expected no write",
                         wr_req_addr, wr_req_mdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (wr_req_addr === mon_exp.addr && wr_req_mdata === mon_exp.mdata
                    && wr_req_data === mon_exp.data) begin
                    pass_cnt++;
                    $display("write addr=0x%05h mdata=0x%04h ok", wr_req_addr, wr_req_mdata);
                end else begin
                    $display("FAIL write: got addr 0x%0h mdata 0x%0h data[31:0] 0x%0h, expected addr 0x%0h mdata 0x%0h data[31:0] 0x%0h",
                             wr_req_addr, wr_req_mdata, wr_req_data[31:0],
                             mon_exp.addr, mon_exp.mdata, mon_exp.data[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef WR_ARB_PRIO_EN
        bv_port = '{1, 1, 1, 1};
        bv_md   = '{14'h2001, 14'h2002, 14'h2003, 14'h2004};
`else
        bv_port = '{1, 0, 1, 0};
        bv_md   = '{14'h2001, 14'h0002, 14'h2003, 14'h0004};
`endif
        seq = 0;
        rst = 1'b1; start = 1'b0; flush = 1'b0; wr_req_almostfull = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        wr_rsp0_valid = 1'b0; wr_rsp0_mdata = '0;
        wr_rsp1_valid = 1'b0; wr_rsp1_mdata = '0;
        repeat (3) step();

        // Reset state
        @(negedge clk);
        check("rst_wr_req_en", wr_req_en, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_busy", busy, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_done", {req1_done, req0_done}, 0);
        check("rst_mdata", wr_req_mdata, 0);

        // First write from port 0
        step();
        rst = 1'b0; start = 1'b1;
        req0_valid = 1'b1; req0_addr = 20'h00010; req0_data = {64{8'hA5}};
        @(negedge clk);
        check("idle_no_ready", req0_ready, 0);
        step();
        @(negedge clk);
        check("first_ready", {req1_ready, req0_ready}, 2'b01);
        check("first_busy", busy, 1);
        exp_q.push_back(mk_wr(20'h00010, 14'h0000, {64{8'hA5}}));
        seq++;
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        check("first_outstanding", outstanding, 1);

        // Both requesters valid for four grants
        p0_addr = 20'h00100; p1_addr = 20'h00180;
        step();
        req0_valid = 1'b1; req0_addr = p0_addr; req0_data = mkdata(p0_addr);
        req1_valid = 1'b1; req1_addr = p1_addr; req1_data = mkdata(p1_addr);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("both_valid_grant", {req1_ready, req0_ready}, (bv_port[i] == 1) ? 2'b10 : 2'b01);
            if (bv_port[i] == 1)
                exp_q.push_back(mk_wr(p1_addr, bv_md[i], mkdata(p1_addr)));
            else
                exp_q.push_back(mk_wr(p0_addr, bv_md[i], mkdata(p0_addr)));
            seq++;
            step();
            if (bv_port[i] == 1) begin
                p1_addr++; req1_addr = p1_addr; req1_data = mkdata(p1_addr);
            end else begin
                p0_addr++; req0_addr = p0_addr; req0_data = mkdata(p0_addr);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("both_valid_outstanding", outstanding, 5);

        // Almostfull blocks grants; release resumes on port 1 in both builds
        step();
        wr_req_almostfull = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("af_ready", {req1_ready, req0_ready}, 2'b00);
        step();
        @(negedge clk);
        check("af_no_issue", wr_req_en, 0);
        step();
        wr_req_almostfull = 1'b0;
        @(negedge clk);
        check("af_release_grant", {req1_ready, req0_ready}, 2'b10);
        exp_q.push_back(mk_wr(p1_addr, 14'h2005, mkdata(p1_addr)));
        seq++;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("af_outstanding", outstanding, 6);

        // Fill to the cap with port 0
        step();
        p0_addr = 20'h00200;
        req0_valid = 1'b1; req0_addr = p0_addr; req0_data = mkdata(p0_addr);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            check("fill_ready", req0_ready, 1);
            exp_q.push_back(mk_wr(p0_addr, {1'b0, 13'(seq)}, mkdata(p0_addr)));
            seq++;
            step();
            p0_addr++; req0_addr = p0_addr; req0_data = mkdata(p0_addr);
        end
        req1_valid = 1'b1; req1_addr = 20'h00300; req1_data = mkdata(20'h00300);
        @(negedge clk);
        check("cap_ready", {req1_ready, req0_ready}, 2'b00);
        check("cap_outstanding", outstanding, 32);
        step();
        @(negedge clk);
        check("cap_no_issue", wr_req_en, 0);
        step();
        wr_rsp0_valid = 1'b1; wr_rsp0_mdata = 14'h2005;
        @(negedge clk);
        check("cap_ready_during_rsp", {req1_ready, req0_ready}, 2'b00);
        step();
        wr_rsp0_valid = 1'b0;
        @(negedge clk);
        check("rsp_port1_done", {req1_done, req0_done}, 4'b0100);
        check("rsp_outstanding", outstanding, 31);
        check("resume_grant", {req1_ready, req0_ready}, 2'b10);
        exp_q.push_back(mk_wr(20'h00300, 14'h2020, mkdata(20'h00300)));
        seq++;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("resume_outstanding", outstanding, 32);
        check("done_is_pulse", req1_done, 0);

        // Two port-0 responses alongside a new accept
        step();
        wr_rsp1_valid = 1'b1; wr_rsp1_mdata = 14'h0008;
        step();
        wr_rsp1_valid = 1'b0;
        @(negedge clk);
        check("rsp1_port0_done", {req1_done, req0_done}, 4'b0001);
        check("rsp1_outstanding", outstanding, 31);
        step();
        req0_valid = 1'b1; req0_addr = 20'h00400; req0_data = mkdata(20'h00400);
        wr_rsp0_valid = 1'b1; wr_rsp0_mdata = 14'h0006;
        wr_rsp1_valid = 1'b1; wr_rsp1_mdata = 14'h0007;
        @(negedge clk);
        check("dual_rsp_ready", {req1_ready, req0_ready}, 2'b01);
        exp_q.push_back(mk_wr(20'h00400, 14'h0021, mkdata(20'h00400)));
        seq++;
        step();
        req0_valid = 1'b0; wr_rsp0_valid = 1'b0; wr_rsp1_valid = 1'b0;
        @(negedge clk);
        check("dual_rsp_done", {req1_done, req0_done}, 4'b0010);
        check("dual_rsp_outstanding", outstanding, 30);

        // Retire down to 3 outstanding
        step();
        for (int i = 0; i < 13; i++) begin
            wr_rsp0_valid = 1'b1; wr_rsp0_mdata = 14'h0009;
            wr_rsp1_valid = 1'b1; wr_rsp1_mdata = 14'h2001;
            step();
            check("split_done", {req1_done, req0_done}, 4'b0101);
        end
        wr_rsp1_valid = 1'b0;
        step();
        check("single_done", {req1_done, req0_done}, 4'b0001);
        wr_rsp0_valid = 1'b0;
        step();
        check("pre_flush_outstanding", outstanding, 3);

        // Flush with 3 outstanding
        flush = 1'b1;
        step();
        flush = 1'b0;
        req0_valid = 1'b1; req0_addr = 20'h00600; req0_data = mkdata(20'h00600);
        req1_valid = 1'b1; req1_addr = 20'h00680; req1_data = mkdata(20'h00680);
        @(negedge clk);
        check("drain_no_grant", {req1_ready, req0_ready}, 2'b00);
        check("drain_busy", busy, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            wr_rsp0_valid = 1'b1; wr_rsp0_mdata = 14'h000A;
            step();
            wr_rsp0_valid = 1'b0;
            if (k == 2) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            check("drain_outstanding", outstanding, 2 - k);
            check("drain_flush_done", flush_done, (k == 2) ? 1 : 0);
        end
        check("drain_back_to_run", busy, 1);
        step();
        check("flush_done_pulse", flush_done, 0);

        // Reset in the middle of a drain
        accept_port0(20'h00500);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("mid_drain_outstanding", outstanding, 1);
        rst = 1'b1; req0_valid = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_outstanding", outstanding, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_en_flush", {wr_req_en, flush_done}, 2'b00);
        check("mid_rst_ready", {req1_ready, req0_ready}, 2'b00);
        req0_valid = 1'b0;

        // A response with nothing outstanding is dropped
        wr_rsp0_valid = 1'b1; wr_rsp0_mdata = 14'h0022;
        step();
        wr_rsp0_valid = 1'b0;
        check("underflow_done", req0_done, 0);
        check("underflow_outstanding", outstanding, 0);

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
